// File: rtl/wb_soc_master_if.sv
// Bundle of the command/response port and the Wishbone classic bus of wb_soc_master.
// The master modport is the initiator's view; slave is the environment (command source plus bus target).
interface wb_soc_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [31:0] p_wb_ADR_O;
  logic [31:0] p_wb_DAT_O;
  logic [31:0] p_wb_DAT_I;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O;
  logic        p_wb_CYC_O;
  logic        p_wb_STB_O;
  logic        p_wb_LOCK_O;
  logic        p_wb_ACK_I;
  logic        p_wb_ERR_I;
  logic        p_wb_RTY_I;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
    output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O, p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
    input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O, p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );
endinterface

// File: rtl/wb_soc_master.sv
// Single-outstanding Wishbone classic-cycle initiator: one command in, one bus cycle out,
// one response pulse back, with bounded RTY retries, ERR reporting and a per-attempt timeout.
module wb_soc_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 p_clk,
  input  logic                 p_resetn,
  wb_soc_master_if.master      bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_ERR   = 2'b01;
  localparam logic [1:0] STS_TMO   = 2'b10;
  localparam logic [1:0] STS_RETRY = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          accept_s;

  assign bus.cmd_ready = (state_q == ST_IDLE) && p_resetn;
  assign accept_s      = bus.cmd_valid && bus.cmd_ready;

  // Next-state logic; response fields only change on entry to RESP so they hold afterwards.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          adr_d   = bus.cmd_addr;
          dat_d   = bus.cmd_data;
          sel_d   = bus.cmd_sel;
          we_d    = bus.cmd_we;
          retry_d = {RW{1'b0}};
          tmo_d   = {TW{1'b0}};
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end else begin
          cyc_d   = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus.p_wb_ERR_I) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STS_ERR;
          rsp_data_d   = 32'h0000_0000;
          state_d      = ST_RESP;
        end else if (bus.p_wb_RTY_I) begin
          cyc_d = 1'b0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_GAP;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = STS_RETRY;
            rsp_data_d   = 32'h0000_0000;
            state_d      = ST_RESP;
          end
        end else if (bus.p_wb_ACK_I) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STS_OK;
          rsp_data_d   = we_q ? 32'h0000_0000 : bus.p_wb_DAT_I;
          state_d      = ST_RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // The attempt's last allowed cycle just passed without any termination.
          tmo_d        = tmo_q + TW'(1);
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STS_TMO;
          rsp_data_d   = 32'h0000_0000;
          state_d      = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        tmo_d   = {TW{1'b0}};
        cyc_d   = 1'b1;
        state_d = ST_BUS;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge p_clk) begin
    if (!p_resetn) begin
      state_q      <= ST_IDLE;
      adr_q        <= 32'h0000_0000;
      dat_q        <= 32'h0000_0000;
      sel_q        <= 4'h0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'h0000_0000;
      rsp_status_q <= 2'b00;
      retry_q      <= {RW{1'b0}};
      tmo_q        <= {TW{1'b0}};
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.p_wb_ADR_O  = adr_q;
  assign bus.p_wb_DAT_O  = dat_q;
  assign bus.p_wb_SEL_O  = sel_q;
  assign bus.p_wb_WE_O   = we_q;
  assign bus.p_wb_CYC_O  = cyc_q;
  assign bus.p_wb_STB_O  = cyc_q;
  assign bus.p_wb_LOCK_O = 1'b0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_status  = rsp_status_q;

endmodule

// File: tb/tb_wb_soc_master.sv
// Directed bench for wb_soc_master: inputs change 1 time unit after posedge, outputs are
// checked there too, and the bus target responds combinationally from its enable flags.
module tb_wb_soc_master;

  logic        clk;
  logic        resetn;
  logic        ack_en, err_en, rty_en;
  logic [31:0] dat_i;
  int          vectors;
  int          miscompares;
  int          cyc_cnt;
  int          rsp_cnt;

  wb_soc_master_if bus ();

  wb_soc_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
    .p_clk    (clk),
    .p_resetn (resetn),
    .bus      (bus.master)
  );

  assign bus.p_wb_ACK_I = ack_en & bus.p_wb_CYC_O & bus.p_wb_STB_O;
  assign bus.p_wb_ERR_I = err_en & bus.p_wb_CYC_O & bus.p_wb_STB_O;
  assign bus.p_wb_RTY_I = rty_en & bus.p_wb_CYC_O & bus.p_wb_STB_O;
  assign bus.p_wb_DAT_I = dat_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one command, wait (bounded) for acceptance, return just after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    int guard;
    guard = 0;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_wait", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    resetn = 1'b0; ack_en = 1'b0; err_en = 1'b0; rty_en = 1'b0; dat_i = 32'h0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_data = 32'h0; bus.cmd_sel = 4'h0;

    // Reset state
    tick(); tick();
    check("rst_ready",  {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_cyc",    {31'd0, bus.p_wb_CYC_O}, 32'd0);
    check("rst_rspv",   {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_status", {30'd0, bus.rsp_status}, 32'd0);
    check("rst_lock",   {31'd0, bus.p_wb_LOCK_O}, 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_ready",  {31'd0, bus.cmd_ready}, 32'd1);

    // 1: zero-wait write
    ack_en = 1'b1;
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    check("t1_cyc",   {31'd0, bus.p_wb_CYC_O}, 32'd1);
    check("t1_stb",   {31'd0, bus.p_wb_STB_O}, 32'd1);
    check("t1_we",    {31'd0, bus.p_wb_WE_O}, 32'd1);
    check("t1_dat",   bus.p_wb_DAT_O, 32'hDEAD_BEEF);
    check("t1_adr",   bus.p_wb_ADR_O, 32'h0000_0100);
    check("t1_sel",   {28'd0, bus.p_wb_SEL_O}, 32'hF);
    check("t1_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("t1_rspv0", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("t1_cyc_off", {31'd0, bus.p_wb_CYC_O}, 32'd0);
    check("t1_rspv",    {31'd0, bus.rsp_valid}, 32'd1);
    check("t1_status",  {30'd0, bus.rsp_status}, 32'd0);
    tick();
    check("t1_rspv_off", {31'd0, bus.rsp_valid}, 32'd0);
    check("t1_ready2",   {31'd0, bus.cmd_ready}, 32'd1);

    // 2: read with 3 wait states; a new command during BUS must not be taken
    ack_en = 1'b0;
    dat_i  = 32'h1234_5678;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      check("t2_stb_wait", {31'd0, bus.p_wb_STB_O}, 32'd1);
      tick();
    end
    check("t2_stb4",  {31'd0, bus.p_wb_STB_O}, 32'd1);
    check("t2_adr",   bus.p_wb_ADR_O, 32'h0000_0200);
    check("t2_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b0;
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    check("t2_rspv",   {31'd0, bus.rsp_valid}, 32'd1);
    check("t2_data",   bus.rsp_data, 32'h1234_5678);
    check("t2_status", {30'd0, bus.rsp_status}, 32'd0);
    tick();
    check("t2_hold_data", bus.rsp_data, 32'h1234_5678);

    // 4: no response -> timeout after 16 bus cycles
    issue(1'b0, 32'h0000_0300, 32'h0, 4'h3);
    cyc_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.p_wb_CYC_O) cyc_cnt++;
      tick();
    end
    check("t4_cyc_cycles", cyc_cnt, 32'd16);
    check("t4_cyc_off",    {31'd0, bus.p_wb_CYC_O}, 32'd0);
    check("t4_rspv",       {31'd0, bus.rsp_valid}, 32'd1);
    check("t4_status",     {30'd0, bus.rsp_status}, 32'd2);
    check("t4_data",       bus.rsp_data, 32'h0);
    tick();

    // 3a: RTY on attempts 1-2, ACK on attempt 3
    rty_en = 1'b1;
    dat_i  = 32'hA5A5_0003;
    issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    check("t3a_cyc1", {31'd0, bus.p_wb_CYC_O}, 32'd1);
    tick();
    check("t3a_gap1", {31'd0, bus.p_wb_CYC_O}, 32'd0);
    check("t3a_norsp1", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("t3a_cyc2", {31'd0, bus.p_wb_CYC_O}, 32'd1);
    tick();
    check("t3a_gap2", {31'd0, bus.p_wb_STB_O}, 32'd0);
    rty_en = 1'b0; ack_en = 1'b1;
    tick();
    check("t3a_cyc3", {31'd0, bus.p_wb_CYC_O}, 32'd1);
    check("t3a_adr3", bus.p_wb_ADR_O, 32'h0000_0400);
    tick();
    check("t3a_rspv",   {31'd0, bus.rsp_valid}, 32'd1);
    check("t3a_status", {30'd0, bus.rsp_status}, 32'd0);
    check("t3a_data",   bus.rsp_data, 32'hA5A5_0003);
    tick();

    // 5: ERR and ACK together -> ERR wins
    err_en = 1'b1; ack_en = 1'b1; dat_i = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    err_en = 1'b0; ack_en = 1'b0;
    check("t5_rspv",   {31'd0, bus.rsp_valid}, 32'd1);
    check("t5_status", {30'd0, bus.rsp_status}, 32'd1);
    check("t5_data",   bus.rsp_data, 32'h0);
    tick();

    // 3b: RTY on every attempt -> retry exhausted after the 4th
    rty_en = 1'b1;
    issue(1'b1, 32'h0000_0600, 32'h0000_0066, 4'h1);
    for (int i = 0; i < 3; i++) begin
      check("t3b_cyc", {31'd0, bus.p_wb_CYC_O}, 32'd1);
      tick();
      check("t3b_gap", {31'd0, bus.p_wb_CYC_O}, 32'd0);
      check("t3b_norsp", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    check("t3b_cyc4", {31'd0, bus.p_wb_CYC_O}, 32'd1);
    tick();
    rty_en = 1'b0;
    check("t3b_rspv",   {31'd0, bus.rsp_valid}, 32'd1);
    check("t3b_status", {30'd0, bus.rsp_status}, 32'd3);
    tick();
    check("t3b_hold_status", {30'd0, bus.rsp_status}, 32'd3);

    // 6: reset pulse mid-BUS abandons the command
    issue(1'b0, 32'h0000_0700, 32'h0, 4'hF);
    tick();
    check("t6_cyc_busy", {31'd0, bus.p_wb_CYC_O}, 32'd1);
    resetn = 1'b0;
    tick();
    check("t6_cyc",   {31'd0, bus.p_wb_CYC_O}, 32'd0);
    check("t6_stb",   {31'd0, bus.p_wb_STB_O}, 32'd0);
    check("t6_rspv",  {31'd0, bus.rsp_valid}, 32'd0);
    check("t6_ready_in_rst", {31'd0, bus.cmd_ready}, 32'd0);
    resetn = 1'b1;
    #1;
    check("t6_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rsp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) rsp_cnt++;
      tick();
    end
    check("t6_no_rsp", rsp_cnt, 32'd0);
    ack_en = 1'b1; dat_i = 32'h0BAD_F00D;
    issue(1'b0, 32'h0000_0800, 32'h0, 4'hF);
    tick();
    ack_en = 1'b0;
    check("t6_after_status", {30'd0, bus.rsp_status}, 32'd0);
    check("t6_after_data",   bus.rsp_data, 32'h0BAD_F00D);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
